// File: rtl/wshb_rr_arbiter.sv
// wshb_rr_arbiter: N-master to 1-slave Wishbone classic arbiter.
// Round-robin or fixed priority, optional ack quantum per grant.
//
// Ports:
//   sys_clk, sys_rst   clock, asynchronous active-high reset
//   m_cyc/m_stb/m_we   per-master request, strobe, write enable (N)
//   m_adr              packed master addresses, master i at [i*AW +: AW]
//   m_dat_ms           packed master write data, master i at [i*DW +: DW]
//   m_sel              packed byte selects, master i at [i*SW +: SW]
//   m_dat_sm           slave read data broadcast to every master
//   m_ack/m_err        per-master termination, only the owner sees it
//   s_*                single slave port driven from the owning master
//   grant              one-hot current owner, zero while idle
//   busy               high while some master owns the bus
module wshb_rr_arbiter #(
    parameter int N       = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RR      = 1,
    parameter int QUANTUM = 0,
    localparam int SW     = DW / 8
) (
    input  logic            sys_clk,
    input  logic            sys_rst,

    input  logic [N-1:0]    m_cyc,
    input  logic [N-1:0]    m_stb,
    input  logic [N-1:0]    m_we,
    input  logic [N*AW-1:0] m_adr,
    input  logic [N*DW-1:0] m_dat_ms,
    input  logic [N*SW-1:0] m_sel,
    output logic [DW-1:0]   m_dat_sm,
    output logic [N-1:0]    m_ack,
    output logic [N-1:0]    m_err,

    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat_ms,
    output logic [SW-1:0]   s_sel,
    input  logic [DW-1:0]   s_dat_sm,
    input  logic            s_ack,
    input  logic            s_err,

    output logic [N-1:0]    grant,
    output logic            busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (QUANTUM > 0) ? $clog2(QUANTUM + 1) : 1;

    // Counter value at which one more termination exhausts the quantum.
    localparam logic [CW-1:0] QLAST =
        (QUANTUM > 0) ? CW'(QUANTUM - 1) : '0;

    // Pointer starts at the last master so master 0 wins first.
    localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

    typedef enum logic {
        S_IDLE,
        S_OWNED
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_grant;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_last;
    logic [CW-1:0]   r_cnt;

    logic            w_owned;
    logic            w_own_cyc;
    logic            w_own_stb;
    logic            w_own_we;
    logic            w_stb;
    logic            w_done;
    logic            w_qhit;
    logic            w_rel;

    logic            w_found;
    logic [IW-1:0]   w_win;
    logic [N-1:0]    w_win_oh;
    int              w_idx;

    // ---------------------------------------------------------------
    // Winner selection, evaluated every cycle but only used in IDLE.
    // RR scans last+1, last+2, ... modulo N; fixed priority scans 0..N-1.
    // ---------------------------------------------------------------
    always_comb begin
        w_found  = 1'b0;
        w_win    = '0;
        w_win_oh = '0;
        w_idx    = 0;
        for (int j = 0; j < N; j++) begin
            if (RR != 0) begin
                w_idx = (int'(r_last) + 1 + j) % N;
            end else begin
                w_idx = j;
            end
            if (!w_found && m_cyc[IW'(w_idx)]) begin
                w_found = 1'b1;
                w_win   = IW'(w_idx);
            end
        end
        w_win_oh[w_win] = 1'b1;
    end

    // ---------------------------------------------------------------
    // Datapath: combinational mux of the owning master.
    // ---------------------------------------------------------------
    assign w_owned   = (r_state == S_OWNED);
    assign w_own_cyc = m_cyc[r_owner];
    assign w_own_stb = m_stb[r_owner];
    assign w_own_we  = m_we[r_owner];

    assign w_stb     = w_owned & w_own_cyc & w_own_stb;

    assign s_cyc     = w_owned & w_own_cyc;
    assign s_stb     = w_stb;
    assign s_we      = w_owned & w_own_we;
    assign s_adr     = m_adr[int'(r_owner) * AW +: AW];
    assign s_dat_ms  = m_dat_ms[int'(r_owner) * DW +: DW];
    assign s_sel     = m_sel[int'(r_owner) * SW +: SW];

    assign m_dat_sm  = s_dat_sm;

    // r_grant is zero in IDLE, so no termination leaks out then.
    assign m_ack     = r_grant & {N{s_ack & w_stb}};
    assign m_err     = r_grant & {N{s_err & w_stb}};

    assign grant     = r_grant;
    assign busy      = |r_grant;

    // ---------------------------------------------------------------
    // Release: owner dropped cyc, or this termination fills the quantum.
    // An err counts against the quantum exactly like an ack.
    // ---------------------------------------------------------------
    assign w_done = w_stb & (s_ack | s_err);
    assign w_qhit = (QUANTUM > 0) && w_done && (r_cnt == QLAST);
    assign w_rel  = ~w_own_cyc | w_qhit;

    // ---------------------------------------------------------------
    // Grant FSM. Every release passes through one IDLE cycle, so the
    // slave always sees s_cyc low between two owners.
    // ---------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_last  <= LAST_RST;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_OWNED;
                        r_grant <= w_win_oh;
                        r_owner <= w_win;
                        r_cnt   <= '0;
                    end
                end
                S_OWNED: begin
                    if (w_rel) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_last  <= r_owner;
                        r_cnt   <= '0;
                    end else if (w_done) begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// tb_wshb_rr_arbiter: two arbiters (RR+quantum, fixed priority) on
// shared stimulus, checked each cycle against a bench-side model.
module tb_wshb_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int SW = DW / 8;

    logic            clk;
    logic            rst;
    logic [N-1:0]    m_cyc;
    logic [N-1:0]    m_stb;
    logic [N-1:0]    m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat_ms;
    logic [N*SW-1:0] m_sel;
    logic [DW-1:0]   s_dat_sm;
    logic            s_ack;
    logic            s_err;

    logic [DW-1:0]   a_dsm, b_dsm;
    logic [N-1:0]    a_ack, b_ack;
    logic [N-1:0]    a_err, b_err;
    logic            a_cyc, b_cyc;
    logic            a_stb, b_stb;
    logic            a_we, b_we;
    logic [AW-1:0]   a_adr, b_adr;
    logic [DW-1:0]   a_dms, b_dms;
    logic [SW-1:0]   a_sel, b_sel;
    logic [N-1:0]    a_grant, b_grant;
    logic            a_busy, b_busy;

    int checks = 0;
    int errors = 0;

    // Instance A: round-robin, quantum 4. Instance B: fixed priority.
    wshb_rr_arbiter #(
        .N(N), .AW(AW), .DW(DW), .RR(1), .QUANTUM(4)
    ) u_a (
        .sys_clk(clk), .sys_rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_adr(m_adr), .m_dat_ms(m_dat_ms), .m_sel(m_sel),
        .m_dat_sm(a_dsm), .m_ack(a_ack), .m_err(a_err),
        .s_cyc(a_cyc), .s_stb(a_stb), .s_we(a_we),
        .s_adr(a_adr), .s_dat_ms(a_dms), .s_sel(a_sel),
        .s_dat_sm(s_dat_sm), .s_ack(s_ack), .s_err(s_err),
        .grant(a_grant), .busy(a_busy)
    );

    wshb_rr_arbiter #(
        .N(N), .AW(AW), .DW(DW), .RR(0), .QUANTUM(0)
    ) u_b (
        .sys_clk(clk), .sys_rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_adr(m_adr), .m_dat_ms(m_dat_ms), .m_sel(m_sel),
        .m_dat_sm(b_dsm), .m_ack(b_ack), .m_err(b_err),
        .s_cyc(b_cyc), .s_stb(b_stb), .s_we(b_we),
        .s_adr(b_adr), .s_dat_ms(b_dms), .s_sel(b_sel),
        .s_dat_sm(s_dat_sm), .s_ack(s_ack), .s_err(s_err),
        .grant(b_grant), .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: owner index (-1 = idle), last owner, terminations this grant.
    int RRV [2] = '{1, 0};
    int QV  [2] = '{4, 0};
    int mown  [2] = '{-1, -1};
    int mlast [2] = '{N - 1, N - 1};
    int mcnt  [2] = '{0, 0};

    function automatic int pick(int k);
        int c;
        for (int j = 0; j < N; j++) begin
            if (RRV[k] != 0) c = (mlast[k] + 1 + j) % N;
            else             c = j;
            if (m_cyc[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int o;
            o = mown[k];
            if (rst) begin
                mown[k]  = -1;
                mlast[k] = N - 1;
                mcnt[k]  = 0;
            end else if (o < 0) begin
                mown[k] = pick(k);
                mcnt[k] = 0;
            end else begin
                if (m_cyc[o] && m_stb[o] && (s_ack || s_err))
                    mcnt[k] = mcnt[k] + 1;
                if (!m_cyc[o] || (QV[k] > 0 && mcnt[k] >= QV[k])) begin
                    mlast[k] = o;
                    mown[k]  = -1;
                    mcnt[k]  = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chk_inst(
        input int k,
        input logic [N-1:0] g, input logic bsy,
        input logic cyc, input logic stb, input logic we,
        input logic [AW-1:0] adr, input logic [DW-1:0] dms,
        input logic [SW-1:0] sel,
        input logic [N-1:0] ack, input logic [N-1:0] err,
        input logic [DW-1:0] dsm
    );
        string p;
        int o;
        logic [N-1:0] eg;
        logic ecyc, estb;
        p = (k == 0) ? "A" : "B";
        o = mown[k];
        eg = '0;
        ecyc = 1'b0;
        estb = 1'b0;
        if (o >= 0) begin
            eg[o] = 1'b1;
            ecyc  = m_cyc[o];
            estb  = ecyc & m_stb[o];
        end
        chk({p, ".grant"}, g, eg);
        chk({p, ".busy"}, bsy, (o >= 0));
        chk({p, ".s_cyc"}, cyc, ecyc);
        chk({p, ".s_stb"}, stb, estb);
        chk({p, ".m_ack"}, ack, (estb && s_ack) ? eg : '0);
        chk({p, ".m_err"}, err, (estb && s_err) ? eg : '0);
        chk({p, ".m_dat_sm"}, dsm, s_dat_sm);
        if (o >= 0) begin
            chk({p, ".s_we"}, we, m_we[o]);
            chk({p, ".s_adr"}, adr, m_adr[o*AW +: AW]);
            chk({p, ".s_dat_ms"}, dms, m_dat_ms[o*DW +: DW]);
            chk({p, ".s_sel"}, sel, m_sel[o*SW +: SW]);
        end else begin
            chk({p, ".s_we_idle"}, we, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        chk_inst(0, a_grant, a_busy, a_cyc, a_stb, a_we,
                 a_adr, a_dms, a_sel, a_ack, a_err, a_dsm);
        chk_inst(1, b_grant, b_busy, b_cyc, b_stb, b_we,
                 b_adr, b_dms, b_sel, b_ack, b_err, b_dsm);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        m_cyc = '0;
        m_stb = '0;
    endtask

    // Hand-derived grant traces for instance A.
    logic [N-1:0] EXPQ [16] = '{
        3'b000, 3'b010, 3'b010, 3'b010, 3'b010,
        3'b000, 3'b100, 3'b100, 3'b100, 3'b100,
        3'b000, 3'b001, 3'b001, 3'b001, 3'b001,
        3'b000
    };
    logic [N-1:0] EXPE [7] = '{
        3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b010
    };

    initial begin
        rst      = 1'b1;
        m_cyc    = '0;
        m_stb    = '0;
        m_we     = 3'b010;
        m_adr    = {24'hC00002, 24'hB00001, 24'hA00000};
        m_dat_ms = {16'h3333, 16'h2222, 16'h1111};
        m_sel    = 6'b10_01_11;
        s_dat_sm = 16'h5A5A;
        s_ack    = 1'b0;
        s_err    = 1'b0;

        @(negedge clk);
        chk("rst.grant", a_grant, 3'b000);
        chk("rst.s_cyc", a_cyc, 1'b0);
        chk("rst.m_ack", a_ack, 3'b000);
        tick();
        rst = 1'b0;

        // Single request from master 0, one cycle arbitration latency.
        tick();
        m_cyc = 3'b001;
        m_stb = 3'b001;
        s_ack = 1'b1;
        @(negedge clk);
        chk("t1.latency_grant", a_grant, 3'b000);
        chk("t1.latency_cyc", a_cyc, 1'b0);
        @(negedge clk);
        chk("t1.grant", a_grant, 3'b001);
        chk("t1.s_cyc", a_cyc, 1'b1);
        chk("t1.s_adr", a_adr, 24'hA00000);
        chk("t1.m_ack", a_ack, 3'b001);
        chk("t1.b_grant", b_grant, 3'b001);
        #1 s_ack = 1'b0;
        #1 chk("t1.ack_follows", a_ack, 3'b000);
        s_ack = 1'b1;
        tick();
        idle_bus();
        repeat (3) tick();

        // All three stream: A rotates 4 acks each, B keeps master 0.
        m_cyc = 3'b111;
        m_stb = 3'b111;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            chk($sformatf("q.a_grant[%0d]", n), a_grant, EXPQ[n]);
            chk($sformatf("q.a_ack[%0d]", n), a_ack, EXPQ[n]);
            chk($sformatf("q.b_grant[%0d]", n), b_grant,
                (n == 0) ? 3'b000 : 3'b001);
        end
        tick();
        idle_bus();
        repeat (3) tick();

        // Slave errors on master 1: err counts toward the quantum.
        m_cyc = 3'b010;
        m_stb = 3'b010;
        s_ack = 1'b0;
        s_err = 1'b1;
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            chk($sformatf("e.a_grant[%0d]", n), a_grant, EXPE[n]);
            chk($sformatf("e.a_err[%0d]", n), a_err, EXPE[n]);
            chk($sformatf("e.a_ack[%0d]", n), a_ack, 3'b000);
            chk($sformatf("e.b_grant[%0d]", n), b_grant,
                (n == 0) ? 3'b000 : 3'b010);
        end
        tick();
        idle_bus();
        s_err = 1'b0;
        s_ack = 1'b1;
        repeat (3) tick();

        // Fixed priority: 0 beats 2 until master 0 drops cyc.
        m_cyc = 3'b101;
        m_stb = 3'b101;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk($sformatf("p.b_grant[%0d]", n), b_grant,
                (n == 0) ? 3'b000 : 3'b001);
        end
        tick();
        m_cyc = 3'b100;
        m_stb = 3'b100;
        @(negedge clk);
        chk("p.b_hold_grant", b_grant, 3'b001);
        chk("p.b_hold_cyc", b_cyc, 1'b0);
        @(negedge clk);
        chk("p.b_gap", b_grant, 3'b000);
        @(negedge clk);
        chk("p.b_grant2", b_grant, 3'b100);
        chk("p.b_ack2", b_ack, 3'b100);
        tick();
        idle_bus();
        repeat (3) tick();

        // Asynchronous reset mid-transfer of master 1.
        m_cyc = 3'b010;
        m_stb = 3'b010;
        s_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("r.grant_before", a_grant, 3'b010);
        chk("r.stb_before", a_stb, 1'b1);
        #1 s_ack = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("r.grant", a_grant, 3'b000);
        chk("r.s_cyc", a_cyc, 1'b0);
        chk("r.s_stb", a_stb, 1'b0);
        chk("r.m_ack", a_ack, 3'b000);
        chk("r.busy", a_busy, 1'b0);
        tick();
        rst   = 1'b0;
        m_cyc = 3'b111;
        m_stb = 3'b111;
        @(negedge clk);
        chk("r.gap", a_grant, 3'b000);
        @(negedge clk);
        chk("r.a_first", a_grant, 3'b001);
        chk("r.b_first", b_grant, 3'b001);

        // Pseudo-random traffic, checked by the per-cycle model.
        for (int i = 0; i < 400; i++) begin
            tick();
            for (int j = 0; j < N; j++)
                if ($urandom_range(0, 3) == 0) m_cyc[j] = ~m_cyc[j];
            m_stb    = 3'($urandom);
            m_we     = 3'($urandom);
            m_adr    = {24'($urandom), 24'($urandom), 24'($urandom)};
            m_dat_ms = {16'($urandom), 16'($urandom), 16'($urandom)};
            m_sel    = 6'($urandom);
            s_dat_sm = 16'($urandom);
            s_ack    = 1'($urandom);
            s_err    = ($urandom_range(0, 7) == 0);
        end
        tick();
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
